// File: rtl/tanimoto_ctrl_if.sv
// Signal bundle between tanimoto_ctrl and its host FIFOs, datapath and result consumer.
// Defining TANIMOTO_CTRL_THR_SKIP_EN adds the i_Skip_Thr start qualifier.
interface tanimoto_ctrl_if #(
    parameter int BUS_WIDTH    = 128,
    parameter int VECTOR_WIDTH = 920,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
    parameter int VEC_ID_WIDTH = $clog2(VECTOR_WIDTH),
    parameter int BEAT_WIDTH   = 32
);
    logic                      i_Start;
`ifdef TANIMOTO_CTRL_THR_SKIP_EN
    logic                      i_Skip_Thr;
`endif
    logic [BEAT_WIDTH-1:0]     i_Ref_Beats;
    logic [BEAT_WIDTH-1:0]     i_Cmp_Beats;
    logic [CNT_WIDTH:0]        i_Thr_Data;
    logic                      i_Thr_Valid;
    logic                      o_Thr_Read;
    logic [BUS_WIDTH-1:0]      i_Src_Vector;
    logic                      i_Src_Valid;
    logic                      o_Src_Read;
    logic [BUS_WIDTH-1:0]      o_Vector;
    logic                      o_Valid;
    logic                      o_Last;
    logic                      i_Read;
    logic [CNT_WIDTH-1:0]      o_BRAM_Addr;
    logic [CNT_WIDTH:0]        o_BRAM_Din;
    logic                      o_BRAM_En;
    logic                      o_BRAM_WrEn;
    logic                      i_IDPair_Ready;
    logic [2*VEC_ID_WIDTH-1:0] i_IDPair_Out;
    logic                      i_IDPair_Last;
    logic                      o_IDPair_Read;
    logic                      o_Res_Valid;
    logic [2*VEC_ID_WIDTH-1:0] o_Res_Data;
    logic                      i_Res_Ready;
    logic                      o_Busy;
    logic                      o_Ref_Phase;
    logic                      o_Done;
    logic                      o_Error;
    logic [BEAT_WIDTH-1:0]     o_Pair_Count;

    // Controller side.
    modport slave (
`ifdef TANIMOTO_CTRL_THR_SKIP_EN
        input  i_Skip_Thr,
`endif
        input  i_Start, i_Ref_Beats, i_Cmp_Beats, i_Thr_Data, i_Thr_Valid,
        input  i_Src_Vector, i_Src_Valid, i_Read,
        input  i_IDPair_Ready, i_IDPair_Out, i_IDPair_Last, i_Res_Ready,
        output o_Thr_Read, o_Src_Read, o_Vector, o_Valid, o_Last,
        output o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn,
        output o_IDPair_Read, o_Res_Valid, o_Res_Data,
        output o_Busy, o_Ref_Phase, o_Done, o_Error, o_Pair_Count
    );

    // Environment side (FIFOs, datapath, consumer).
    modport master (
`ifdef TANIMOTO_CTRL_THR_SKIP_EN
        output i_Skip_Thr,
`endif
        output i_Start, i_Ref_Beats, i_Cmp_Beats, i_Thr_Data, i_Thr_Valid,
        output i_Src_Vector, i_Src_Valid, i_Read,
        output i_IDPair_Ready, i_IDPair_Out, i_IDPair_Last, i_Res_Ready,
        input  o_Thr_Read, o_Src_Read, o_Vector, o_Valid, o_Last,
        input  o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn,
        input  o_IDPair_Read, o_Res_Valid, o_Res_Data,
        input  o_Busy, o_Ref_Phase, o_Done, o_Error, o_Pair_Count
    );
endinterface

// File: rtl/tanimoto_ctrl.sv
// Job sequencer for tanimoto_top: threshold load, vector streaming, result forwarding.
// Defining TANIMOTO_CTRL_THR_SKIP_EN lets a job reuse the thresholds already in the BRAM.
module tanimoto_ctrl #(
    parameter int VECTOR_WIDTH = 920,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
    parameter int BEAT_WIDTH   = 32
) (
    input logic           clk,
    input logic           rst,
    tanimoto_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD_THR, S_STREAM, S_DRAIN, S_DONE} state_e;

    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(VECTOR_WIDTH - 1);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  addr_q, addr_d;
    logic [BEAT_WIDTH-1:0] beat_q, beat_d;
    logic [BEAT_WIDTH-1:0] ref_q, ref_d;
    logic [BEAT_WIDTH-1:0] total_q, total_d;
    logic [BEAT_WIDTH-1:0] pair_q, pair_d;
    logic                  last_seen_q, last_seen_d;
    logic                  error_q, error_d;
    logic                  bram_en_q;

    logic [BEAT_WIDTH-1:0] total_start;
    logic                  res_active, res_xfer, beat_xfer, at_last_beat, skip_thr;

`ifdef TANIMOTO_CTRL_THR_SKIP_EN
    assign skip_thr = bus.i_Skip_Thr;
`else
    assign skip_thr = 1'b0;
`endif

    assign total_start  = bus.i_Ref_Beats + bus.i_Cmp_Beats;
    assign res_active   = (state_q != S_IDLE);
    assign res_xfer     = res_active && bus.i_IDPair_Ready && bus.i_Res_Ready;
    assign beat_xfer    = bus.i_Src_Valid && bus.i_Read;
    assign at_last_beat = (beat_q == total_q - BEAT_WIDTH'(1));

    assign bus.o_Busy       = res_active;
    assign bus.o_Error      = error_q;
    assign bus.o_Pair_Count = pair_q;
    assign bus.o_BRAM_En    = bram_en_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        ref_d       = ref_q;
        total_d     = total_q;
        pair_d      = pair_q;
        last_seen_d = last_seen_q;
        error_d     = error_q;

        bus.o_Thr_Read    = 1'b0;
        bus.o_BRAM_WrEn   = 1'b0;
        bus.o_BRAM_Addr   = '0;
        bus.o_BRAM_Din    = '0;
        bus.o_Vector      = '0;
        bus.o_Valid       = 1'b0;
        bus.o_Src_Read    = 1'b0;
        bus.o_Last        = 1'b0;
        bus.o_Ref_Phase   = 1'b0;
        bus.o_Done        = 1'b0;
        bus.o_Res_Valid   = res_active && bus.i_IDPair_Ready;
        bus.o_Res_Data    = res_active ? bus.i_IDPair_Out : '0;
        bus.o_IDPair_Read = res_active && bus.i_Res_Ready;

        // A last-flagged result before the stream has finished is a protocol error.
        if (res_xfer) begin
            pair_d = pair_q + BEAT_WIDTH'(1);
            if (bus.i_IDPair_Last) begin
                last_seen_d = 1'b1;
                if (state_q == S_LOAD_THR || state_q == S_STREAM) error_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_Start) begin
                    ref_d       = bus.i_Ref_Beats;
                    total_d     = total_start;
                    addr_d      = '0;
                    beat_d      = '0;
                    pair_d      = '0;
                    last_seen_d = 1'b0;
                    error_d     = 1'b0;
                    if (!skip_thr) begin
                        state_d = S_LOAD_THR;
                    end else if (total_start == '0) begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_LOAD_THR: begin
                bus.o_Thr_Read  = bus.i_Thr_Valid;
                bus.o_BRAM_WrEn = bus.i_Thr_Valid;
                bus.o_BRAM_Addr = addr_q;
                bus.o_BRAM_Din  = bus.i_Thr_Data;
                if (bus.i_Thr_Valid) begin
                    addr_d = addr_q + CNT_WIDTH'(1);
                    if (addr_q == LAST_ADDR) begin
                        if (total_q == '0) begin
                            state_d = S_DONE;
                            error_d = 1'b1;
                        end else begin
                            state_d = S_STREAM;
                        end
                    end
                end
            end
            S_STREAM: begin
                bus.o_Vector    = bus.i_Src_Vector;
                bus.o_Valid     = bus.i_Src_Valid;
                bus.o_Src_Read  = beat_xfer;
                bus.o_Last      = bus.i_Src_Valid && at_last_beat;
                bus.o_Ref_Phase = (beat_q < ref_q);
                if (beat_xfer) begin
                    beat_d = beat_q + BEAT_WIDTH'(1);
                    if (at_last_beat) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_seen_q || (res_xfer && bus.i_IDPair_Last)) state_d = S_DONE;
            end
            S_DONE: begin
                bus.o_Done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            ref_q       <= '0;
            total_q     <= '0;
            pair_q      <= '0;
            last_seen_q <= 1'b0;
            error_q     <= 1'b0;
            bram_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            ref_q       <= ref_d;
            total_q     <= total_d;
            pair_q      <= pair_d;
            last_seen_q <= last_seen_d;
            error_q     <= error_d;
            bram_en_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tanimoto_ctrl.sv
// Self-checking bench for tanimoto_ctrl: job-level model checked every cycle plus literal pins.
// Covers nominal, backpressure, zero-length, mid-job reset, early-last and (with the macro) skip jobs.
`timescale 1ns/1ps
module tb_tanimoto_ctrl;
    localparam int BUS_WIDTH    = 128;
    localparam int VECTOR_WIDTH = 920;
    localparam int CNT_WIDTH    = $clog2(VECTOR_WIDTH);
    localparam int VEC_ID_WIDTH = $clog2(VECTOR_WIDTH);
    localparam int BEAT_WIDTH   = 32;
    localparam int PAIR_W       = 2 * VEC_ID_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tanimoto_ctrl_if #(
        .BUS_WIDTH(BUS_WIDTH), .VECTOR_WIDTH(VECTOR_WIDTH), .CNT_WIDTH(CNT_WIDTH),
        .VEC_ID_WIDTH(VEC_ID_WIDTH), .BEAT_WIDTH(BEAT_WIDTH)
    ) bus ();

    tanimoto_ctrl #(.VECTOR_WIDTH(VECTOR_WIDTH), .CNT_WIDTH(CNT_WIDTH), .BEAT_WIDTH(BEAT_WIDTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int tot = 0;
    int bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PAIR_W-1:0] pair_code(input int i);
        return {VEC_ID_WIDTH'(i), VEC_ID_WIDTH'(i * 7 + 3)};
    endfunction

    // ---------------- job-level model ----------------
    typedef enum int {P_IDLE, P_LOAD, P_STREAM, P_DRAIN, P_DONE} phase_e;
    phase_e      m_ph = P_IDLE;
    int          m_writes = 0;
    logic [31:0] m_ref = '0, m_total = '0, m_beats = '0, m_pairs = '0;
    bit          m_seen = 1'b0, m_err = 1'b0, m_en = 1'b0;

    task automatic model_step();
        bit     res_x;
        phase_e nxt;
        if (rst) begin
            m_ph = P_IDLE; m_writes = 0; m_ref = '0; m_total = '0; m_beats = '0;
            m_pairs = '0; m_seen = 1'b0; m_err = 1'b0; m_en = 1'b0;
            return;
        end
        m_en  = 1'b1;
        nxt   = m_ph;
        res_x = (m_ph != P_IDLE) && bus.i_IDPair_Ready && bus.i_Res_Ready;
        case (m_ph)
            P_IDLE: if (bus.i_Start) begin
                m_ref = bus.i_Ref_Beats;
                m_total = bus.i_Ref_Beats + bus.i_Cmp_Beats;
                m_writes = 0; m_beats = '0; m_pairs = '0; m_seen = 1'b0; m_err = 1'b0;
                nxt = P_LOAD;
`ifdef TANIMOTO_CTRL_THR_SKIP_EN
                if (bus.i_Skip_Thr) begin
                    if (m_total == 0) begin nxt = P_DONE; m_err = 1'b1; end
                    else nxt = P_STREAM;
                end
`endif
            end
            P_LOAD: if (bus.i_Thr_Valid) begin
                m_writes++;
                if (m_writes == VECTOR_WIDTH) begin
                    if (m_total == 0) begin nxt = P_DONE; m_err = 1'b1; end
                    else nxt = P_STREAM;
                end
            end
            P_STREAM: if (bus.i_Src_Valid && bus.i_Read) begin
                m_beats++;
                if (m_beats == m_total) nxt = P_DRAIN;
            end
            P_DRAIN: if (m_seen || (res_x && bus.i_IDPair_Last)) nxt = P_DONE;
            P_DONE: nxt = P_IDLE;
            default: nxt = P_IDLE;
        endcase
        if (res_x) begin
            m_pairs++;
            if (bus.i_IDPair_Last) begin
                m_seen = 1'b1;
                if (m_ph == P_LOAD || m_ph == P_STREAM) m_err = 1'b1;
            end
        end
        m_ph = nxt;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- environment (FIFOs, datapath, consumer) ----------------
    int mode = 0;
    int n_pairs = 0;
    bit last_ok = 1'b0;
    bit thr_pop_n = 1'b0, src_pop_n = 1'b0, res_pop_n = 1'b0, job_start_n = 1'b0;

    initial begin
        int thr_idx = 0, src_idx = 0, sent = 0;
        bus.i_Thr_Valid = 1'b0; bus.i_Thr_Data = '0; bus.i_Src_Valid = 1'b0; bus.i_Src_Vector = '0;
        bus.i_Read = 1'b0; bus.i_IDPair_Ready = 1'b0; bus.i_IDPair_Out = '0; bus.i_IDPair_Last = 1'b0;
        bus.i_Res_Ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (job_start_n) begin
                thr_idx = 0; src_idx = 0; sent = 0;
            end else begin
                if (thr_pop_n) thr_idx++;
                if (src_pop_n) src_idx++;
                if (res_pop_n) sent++;
            end
            bus.i_Thr_Valid  = (mode == 0) || (cyc % 3 != 0);
            bus.i_Thr_Data   = (CNT_WIDTH+1)'(thr_idx + 1);
            bus.i_Src_Valid  = (mode == 0) || (cyc % 3 != 2);
            bus.i_Read       = (mode == 0) || (cyc % 4 == 0);
            bus.i_Src_Vector = {32'(src_idx), ~32'(src_idx), 32'(src_idx * 3), 32'hC0DE_0000 | 32'(src_idx)};
            bus.i_IDPair_Ready = (sent < n_pairs) && ((sent != n_pairs - 1) || last_ok) &&
                                 ((mode == 0) || (cyc % 3 != 1));
            bus.i_IDPair_Out  = pair_code(sent);
            bus.i_IDPair_Last = (sent == n_pairs - 1);
            bus.i_Res_Ready   = (mode == 0) || cyc[1];
        end
    end

    // ---------------- compare process and statistics ----------------
    int wr_cnt = 0, wr_bad = 0, last_wr_addr = -1, last_wr_data = -1;
    int pops = 0, ref_pops = 0, last_cnt = 0, last_idx = -1, first_pop_cyc = -1, start_cyc = -1;
    int rx_cnt = 0, rx_bad = 0, rx_last_cyc = -1, done_cnt = 0, done_cyc = -1;

    initial forever begin
        bit stream;
        @(negedge clk);
        thr_pop_n   = bus.o_Thr_Read;
        src_pop_n   = bus.o_Src_Read;
        res_pop_n   = bus.o_IDPair_Read && bus.i_IDPair_Ready;
        job_start_n = !rst && bus.i_Start && (m_ph == P_IDLE);
        if (job_start_n) begin
            wr_cnt = 0; wr_bad = 0; last_wr_addr = -1; last_wr_data = -1;
            pops = 0; ref_pops = 0; last_cnt = 0; last_idx = -1; first_pop_cyc = -1; start_cyc = cyc;
            rx_cnt = 0; rx_bad = 0; rx_last_cyc = -1; done_cnt = 0; done_cyc = -1;
        end
        if (!rst) begin
            stream = (m_ph == P_STREAM);
            check("busy", 128'(bus.o_Busy), 128'(m_ph != P_IDLE));
            check("done", 128'(bus.o_Done), 128'(m_ph == P_DONE));
            check("bram_en", 128'(bus.o_BRAM_En), 128'(m_en));
            check("error", 128'(bus.o_Error), 128'(m_err));
            check("pair_count", 128'(bus.o_Pair_Count), 128'(m_pairs));
            check("thr_read", 128'(bus.o_Thr_Read), 128'(m_ph == P_LOAD && bus.i_Thr_Valid));
            check("bram_wren", 128'(bus.o_BRAM_WrEn), 128'(m_ph == P_LOAD && bus.i_Thr_Valid));
            if (bus.o_BRAM_WrEn) begin
                check("bram_addr", 128'(bus.o_BRAM_Addr), 128'(m_writes));
                check("bram_din", 128'(bus.o_BRAM_Din), 128'(bus.i_Thr_Data));
            end
            check("valid", 128'(bus.o_Valid), 128'(stream && bus.i_Src_Valid));
            check("src_read", 128'(bus.o_Src_Read), 128'(stream && bus.i_Src_Valid && bus.i_Read));
            check("last", 128'(bus.o_Last), 128'(stream && bus.i_Src_Valid && (m_beats == m_total - 1)));
            check("ref_phase", 128'(bus.o_Ref_Phase), 128'(stream && (m_beats < m_ref)));
            if (bus.o_Valid) check("vector", bus.o_Vector, bus.i_Src_Vector);
            check("res_valid", 128'(bus.o_Res_Valid), 128'((m_ph != P_IDLE) && bus.i_IDPair_Ready));
            check("idpair_read", 128'(bus.o_IDPair_Read), 128'((m_ph != P_IDLE) && bus.i_Res_Ready));
            if (bus.o_Res_Valid) check("res_data", 128'(bus.o_Res_Data), 128'(bus.i_IDPair_Out));

            if (bus.o_BRAM_WrEn) begin
                wr_cnt++;
                if (bus.o_BRAM_Din != (CNT_WIDTH+1)'(bus.o_BRAM_Addr + 1)) wr_bad++;
                last_wr_addr = int'(bus.o_BRAM_Addr);
                last_wr_data = int'(bus.o_BRAM_Din);
            end
            if (bus.o_Src_Read) begin
                if (bus.o_Last) begin last_cnt++; last_idx = pops; end
                if (bus.o_Ref_Phase) ref_pops++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                pops++;
            end
            if (bus.o_Res_Valid && bus.i_Res_Ready) begin
                if (bus.o_Res_Data != pair_code(rx_cnt)) rx_bad++;
                if (bus.i_IDPair_Last) rx_last_cyc = cyc;
                rx_cnt++;
            end
            if (bus.o_Done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic start_job(input int r, input int c, input int np, input int md, input bit early);
        mode = md; n_pairs = np; last_ok = early;
        @(posedge clk); #1;
        bus.i_Start = 1'b1; bus.i_Ref_Beats = 32'(r); bus.i_Cmp_Beats = 32'(c);
        @(posedge clk); #1;
        bus.i_Start = 1'b0;
    endtask

    task automatic finish_job(input int total);
        int n = 0;
        int budget = VECTOR_WIDTH * 2 + total * 8 + 200;
        while (pops < total && n < budget) begin @(posedge clk); #1; n++; end
        last_ok = 1'b1;
        while (done_cnt == 0 && n < budget) begin @(posedge clk); #1; n++; end
        check("job_done_seen", 128'(done_cnt != 0), 128'(1));
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus.i_Start = 1'b0; bus.i_Ref_Beats = '0; bus.i_Cmp_Beats = '0;
`ifdef TANIMOTO_CTRL_THR_SKIP_EN
        bus.i_Skip_Thr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 128'(bus.o_Busy), 128'(0));
        check("rst_bram_en", 128'(bus.o_BRAM_En), 128'(0));
        check("rst_pair_count", 128'(bus.o_Pair_Count), 128'(0));
        @(negedge clk);
        check("bram_en_after_reset", 128'(bus.o_BRAM_En), 128'(1));

        // Nominal: ref=58, cmp=920, thresholds 1..920, 37 results.
        start_job(58, 920, 37, 0, 1'b0);
        finish_job(978);
        check("j1_writes", 128'(wr_cnt), 128'(920));
        check("j1_wr_data", 128'(wr_bad), 128'(0));
        check("j1_last_wr_addr", 128'(last_wr_addr), 128'(919));
        check("j1_last_wr_data", 128'(last_wr_data), 128'(920));
        check("j1_pops", 128'(pops), 128'(978));
        check("j1_ref_pops", 128'(ref_pops), 128'(58));
        check("j1_last_count", 128'(last_cnt), 128'(1));
        check("j1_last_idx", 128'(last_idx), 128'(977));
        check("j1_done_count", 128'(done_cnt), 128'(1));
        check("j1_pair_count", 128'(bus.o_Pair_Count), 128'(37));
        check("j1_rx_order", 128'(rx_bad), 128'(0));
        check("j1_done_latency", 128'(done_cyc - rx_last_cyc), 128'(1));
        check("j1_error", 128'(bus.o_Error), 128'(0));

        // Backpressure on every interface, same lengths.
        start_job(58, 920, 37, 1, 1'b0);
        finish_job(978);
        check("j2_writes", 128'(wr_cnt), 128'(920));
        check("j2_pops", 128'(pops), 128'(978));
        check("j2_last_count", 128'(last_cnt), 128'(1));
        check("j2_last_idx", 128'(last_idx), 128'(977));
        check("j2_rx", 128'(rx_cnt), 128'(37));
        check("j2_rx_order", 128'(rx_bad), 128'(0));
        check("j2_pair_count", 128'(bus.o_Pair_Count), 128'(37));
        check("j2_done_latency", 128'(done_cyc - rx_last_cyc), 128'(1));

        // Zero-length job.
        start_job(0, 0, 0, 0, 1'b0);
        finish_job(0);
        check("j3_writes", 128'(wr_cnt), 128'(920));
        check("j3_pops", 128'(pops), 128'(0));
        check("j3_error", 128'(bus.o_Error), 128'(1));
        check("j3_done_count", 128'(done_cnt), 128'(1));

        // Reset around beat 100 of the stream.
        start_job(58, 920, 0, 0, 1'b0);
        n = 0;
        while (pops < 100 && n < 3000) begin @(posedge clk); #1; n++; end
        check("j4_reached_beat100", 128'(pops >= 100), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("j4_busy", 128'(bus.o_Busy), 128'(0));
        check("j4_src_read", 128'(bus.o_Src_Read), 128'(0));
        check("j4_valid", 128'(bus.o_Valid), 128'(0));
        check("j4_bram_en", 128'(bus.o_BRAM_En), 128'(0));
        check("j4_done", 128'(bus.o_Done), 128'(0));
        check("j4_error", 128'(bus.o_Error), 128'(0));

        // Fresh short job after the reset.
        start_job(3, 2, 2, 0, 1'b0);
        finish_job(5);
        check("j5_pops", 128'(pops), 128'(5));
        check("j5_ref_pops", 128'(ref_pops), 128'(3));
        check("j5_last_idx", 128'(last_idx), 128'(4));
        check("j5_pair_count", 128'(bus.o_Pair_Count), 128'(2));
        check("j5_error", 128'(bus.o_Error), 128'(0));

        // Last-flagged result during the threshold load: error, stream still completes.
        start_job(2, 3, 3, 0, 1'b1);
        finish_job(5);
        check("j6_error", 128'(bus.o_Error), 128'(1));
        check("j6_pops", 128'(pops), 128'(5));
        check("j6_pair_count", 128'(bus.o_Pair_Count), 128'(3));
        check("j6_done_count", 128'(done_cnt), 128'(1));

`ifdef TANIMOTO_CTRL_THR_SKIP_EN
        // Reuse the loaded thresholds: no writes, first pop the cycle after start.
        bus.i_Skip_Thr = 1'b1;
        start_job(2, 2, 1, 0, 1'b0);
        bus.i_Skip_Thr = 1'b0;
        finish_job(4);
        check("skip_writes", 128'(wr_cnt), 128'(0));
        check("skip_first_pop", 128'(first_pop_cyc - start_cyc), 128'(1));
        check("skip_pops", 128'(pops), 128'(4));
`endif

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $fatal(1, "watchdog");
    end
endmodule
